// File: rtl/cnn_weight_pkg.sv
// Shared definitions for the weight-load path: layer codes seen by local_mem_weight,
// sequencer control states and default layer lengths.
package cnn_weight_pkg;

  localparam logic [3:0] IDLE   = 4'b0000;
  localparam logic [3:0] L1     = 4'b0001;
  localparam logic [3:0] L2     = 4'b0010;
  localparam logic [3:0] L4     = 4'b0011;
  localparam logic [3:0] L5     = 4'b0100;
  localparam logic [3:0] L7     = 4'b0101;
  localparam logic [3:0] FINISH = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_HOLD   = 2'd2,
    S_FINISH = 2'd3
  } ctrl_state_e;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_L1_WORDS = 216;
  localparam int DEF_L8_WORDS = 576;
  localparam int DEF_L7_WORDS = 400;

  // Layer index 0..4 walks L1, L2, L4, L5, L7.
  localparam logic [2:0] LAST_LAYER = 3'd4;

  function automatic logic [3:0] layer_code(input logic [2:0] idx);
    case (idx)
      3'd0:    layer_code = L1;
      3'd1:    layer_code = L2;
      3'd2:    layer_code = L4;
      3'd3:    layer_code = L5;
      3'd4:    layer_code = L7;
      default: layer_code = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/counter_cnn.sv
// Element counter with synchronous clear and count enable; saturates instead of wrapping.
module counter_cnn #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/weight_load_sched.sv
// Streams weights into local_mem_weight layer by layer, holding each layer resident
// until the core releases it.
module weight_load_sched
  import cnn_weight_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int L1_WORDS = DEF_L1_WORDS,
  parameter int L8_WORDS = DEF_L8_WORDS,
  parameter int L7_WORDS = DEF_L7_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              layer_release,
  output logic              write_weight_signal,
  output logic [DATA_W-1:0] write_weight_data,
  output logic [15:0]       write_weight_addr,
  output logic [3:0]        weight_fsm_cs,
  output logic              weight_store_done,
  output logic              all_done
);

  ctrl_state_e       state_q, state_d;
  logic [2:0]        layer_q, layer_d;
  logic [3:0]        fsm_cs_q, fsm_cs_d;
  logic              wr_sig_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [15:0]       wr_addr_q;
  logic              store_done_q;
  logic              all_done_q;

  logic [15:0] elem_cnt;
  logic [15:0] cur_len;
  logic        accept;
  logic        last_accept;
  logic        cnt_clr;

  counter_cnn #(.W(16)) u_elem_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (accept),
    .cnt_o (elem_cnt)
  );

  always_comb begin
    case (layer_q)
      3'd0:    cur_len = 16'(L1_WORDS);
      3'd4:    cur_len = 16'(L7_WORDS);
      default: cur_len = 16'(L8_WORDS);
    endcase
  end

  assign in_ready    = (state_q == S_LOAD);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (elem_cnt == cur_len - 16'd1);

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    cnt_clr = 1'b0;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          state_d = S_LOAD;
          layer_d = 3'd0;
          cnt_clr = 1'b1;
        end
      end
      S_LOAD: begin
        if (last_accept) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (layer_release) begin
          if (layer_q == LAST_LAYER) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_LOAD;
            layer_d = layer_q + 3'd1;
            cnt_clr = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Layer code tracks the next state so it flips together with state entry.
    case (state_d)
      S_IDLE:   fsm_cs_d = IDLE;
      S_FINISH: fsm_cs_d = FINISH;
      default:  fsm_cs_d = layer_code(layer_d);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      layer_q      <= 3'd0;
      fsm_cs_q     <= IDLE;
      wr_sig_q     <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      store_done_q <= 1'b0;
      all_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      fsm_cs_q     <= fsm_cs_d;
      wr_sig_q     <= accept;
      wr_data_q    <= accept ? in_data : '0;
      store_done_q <= (state_d == S_HOLD);
      all_done_q   <= (state_d == S_FINISH);
      if (accept) begin
        wr_addr_q <= elem_cnt;
      end
    end
  end

  assign write_weight_signal = wr_sig_q;
  assign write_weight_data   = wr_data_q;
  assign write_weight_addr   = wr_addr_q;
  assign weight_fsm_cs       = fsm_cs_q;
  assign weight_store_done   = store_done_q;
  assign all_done            = all_done_q;

endmodule

// File: tb/tb_weight_load_sched.sv
// Randomized bench for weight_load_sched against a transaction-level model of the layer sequence.
module tb_weight_load_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        layer_release = 1'b0;
  logic        write_weight_signal;
  logic [15:0] write_weight_data;
  logic [15:0] write_weight_addr;
  logic [3:0]  weight_fsm_cs;
  logic        weight_store_done;
  logic        all_done;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Model: phase 0 idle, 1 loading, 2 resident, 3 finished.
  int          m_phase;
  int          m_layer;
  int          m_count;
  logic        m_wsig;
  logic [15:0] m_wdata;
  logic [15:0] m_waddr;
  int          lens  [5] = '{216, 576, 576, 576, 400};
  int          codes [5] = '{1, 2, 3, 4, 5};

  weight_load_sched dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .layer_release       (layer_release),
    .write_weight_signal (write_weight_signal),
    .write_weight_data   (write_weight_data),
    .write_weight_addr   (write_weight_addr),
    .weight_fsm_cs       (weight_fsm_cs),
    .weight_store_done   (weight_store_done),
    .all_done            (all_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h (layer=%0d count=%0d)", tag, got, exp, m_layer, m_count);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_layer = 0;
    m_count = 0;
    m_wsig  = 1'b0;
    m_wdata = '0;
    m_waddr = '0;
  endtask

  task automatic check_outputs();
    int exp_cs;
    exp_cs = (m_phase == 0) ? 0 : (m_phase == 3) ? 15 : codes[m_layer];
    check_val("in_ready",   32'(in_ready),            32'(m_phase == 1));
    check_val("store_done", 32'(weight_store_done),   32'(m_phase == 2));
    check_val("all_done",   32'(all_done),            32'(m_phase == 3));
    check_val("fsm_cs",     32'(weight_fsm_cs),       32'(exp_cs));
    check_val("wr_sig",     32'(write_weight_signal), 32'(m_wsig));
    check_val("wr_data",    32'(write_weight_data),   32'(m_wdata));
    check_val("wr_addr",    32'(write_weight_addr),   32'(m_waddr));
  endtask

  task automatic cycle(input bit s, input bit v, input bit r, input logic [15:0] d);
    bit acc;
    @(negedge clk);
    start = s; in_valid = v; layer_release = r; in_data = d;
    @(posedge clk);
    #1;
    acc     = v && (m_phase == 1);
    m_wsig  = acc;
    m_wdata = acc ? d : 16'h0;
    if (acc) m_waddr = 16'(m_count);
    case (m_phase)
      0, 3: if (s) begin m_phase = 1; m_layer = 0; m_count = 0; end
      1: if (acc) begin
           m_count++;
           if (m_count == lens[m_layer]) m_phase = 2;
         end
      2: if (r) begin
           if (m_layer == 4) m_phase = 3;
           else begin m_layer++; m_count = 0; m_phase = 1; end
         end
      default: ;
    endcase
    check_outputs();
  endtask

  // mode 0: back-to-back, 1: valid pattern 1,0,0, 2: random valid and data.
  task automatic load_layer(input int mode, input int rel_at, input int stop_at);
    int guard = 0;
    bit v;
    logic [15:0] d;
    int code;
    code = codes[m_layer];
    while (m_phase == 1 && m_count != stop_at && guard < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 3 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = (mode == 2) ? 16'($urandom) : 16'(m_count + 256);
      cycle(1'b0, v, (m_count == rel_at), d);
      guard++;
    end
    $display("layer code=%0d mode=%0d words=%0d cycles=%0d phase=%0d", code, mode, m_count, guard, m_phase);
  endtask

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'($urandom));
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    $display("reset and idle checked");

    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    load_layer(0, -1, -1);
    hold_cycles(5);
    cycle(1'b1, 1'b1, 1'b0, 16'hBEEF);
    hold_cycles(3);
    cycle(1'b0, 1'b0, 1'b1, 16'h0);

    load_layer(2, 100, -1);
    hold_cycles(3);
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    load_layer(0, 575, -1);
    hold_cycles(4);
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    load_layer(2, -1, -1);
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    load_layer(1, -1, -1);
    hold_cycles(2);
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
    $display("sequence finished, all_done=%0b", all_done);

    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    load_layer(1, -1, -1);
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    load_layer(2, -1, -1);
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    load_layer(2, -1, 300);

    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; layer_release = 1'b0; in_data = 16'h1234;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    $display("mid-layer reset checked");

    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    load_layer(0, -1, 20);
    hold_cycles(2);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
